register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 Parameter NREG, default 32, number of architectural registers; address width is log2(NREG), 5 bits at the default.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-005 waddr  input  5  write-port register address.
REQ-006 we  input  1  write enable, active-high.
REQ-007 wdata  input  32  write data.
REQ-008 rs1addr  input  5  read-port-1 address.
REQ-009 rs1  output  32  read-port-1 data.
REQ-010 rs2addr  input  5  read-port-2 address.
REQ-011 rs2  output  32  read-port-2 data.
REQ-012 test0..test3  output  32 each  debug taps: stored contents of x1, x2, x3 and x4 respectively.

Function
REQ-013 The block SHALL hold NREG registers x0..x(NREG-1) of XLEN bits each.
REQ-014 Write: on a rising edge with rst_n=1, we=1 and waddr!=0, register x[waddr] SHALL take wdata; write latency is 1 cycle.
REQ-015 With we=0, no register SHALL change.
REQ-016 x0 SHALL always read 0; writes to address 0 SHALL be discarded.
REQ-017 Reads SHALL be combinational (zero latency): rs1 = x[rs1addr] and rs2 = x[rs2addr].
REQ-018 Bypass: when rst_n=1, we=1, waddr!=0 and waddr equals rsNaddr, rsN SHALL return wdata in the same cycle, before the edge.
REQ-019 Address 0 on either read port SHALL return 0 regardless of the bypass condition.
REQ-020 Both read ports SHALL be independent and may address the same register, including the register being written.
REQ-021 test0..test3 SHALL show stored values only, with no bypass; they update one edge after the write.
REQ-022 Any X or undriven read address SHALL not corrupt stored state; only the write path changes state.

Reset
REQ-023 A rising edge with rst_n=0 SHALL clear all registers to 0; after that edge rs1, rs2 and test0..test3 SHALL read 0.
REQ-024 While rst_n=0, writes SHALL be suppressed and the bypass SHALL be disabled; reset has priority over we.
REQ-025 Reset asserted in the middle of a write sequence SHALL clear all registers, including values written in earlier cycles.

Structure
REQ-026 A shared package SHALL define the XLEN and NREG constants and the typedefs word_t (XLEN bits) and regaddr_t (log2(NREG) bits).
REQ-027 The block SHALL be implemented flat, with no sub-module: a storage array, one write process and two read/bypass multiplexers.

Verification
REQ-028 Hold rst_n=0 for 1 edge, then release -> rs1, rs2 and test0..test3 = 0.
REQ-029 Drive waddr=1, wdata=1, we=0 for 1 edge -> test0 stays 0; then set we=1 -> test0=1 after the next edge.
REQ-030 Drive we=1, waddr=0, wdata=1, rs1addr=0 -> rs1=0 before and after the edge; no test tap changes.
REQ-031 Drive we=1, waddr=2, wdata=3, rs1addr=1, rs2addr=2 -> rs1=1 and rs2=3 in the same cycle via bypass; test1 reads 0 before the edge and 3 after it.
REQ-032 Write x3=0xDEADBEEF and x4=5, then pulse rst_n=0 with we=1 -> all outputs 0 and the write during reset is lost.
REQ-033 Set rs1addr=rs2addr=4 while writing x4=7 -> both ports return 7 combinationally, and test3=7 after the edge.

Source files
------------

// File: rtl/register_pkg.sv
// Shared constants and types for the architectural register file.
package register_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   regaddr_t;

endpackage

// File: rtl/register.sv
// Register file: one write port and two combinational read ports with same-cycle
// write bypass. x0 is hard-wired to zero. x1..x4 are exposed as debug taps.
module register #(
  parameter int XLEN = register_pkg::XLEN,
  parameter int NREG = register_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   waddr,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   rs1addr,
  output logic [XLEN-1:0] rs1,
  input  logic [AW-1:0]   rs2addr,
  output logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] test0,
  output logic [XLEN-1:0] test1,
  output logic [XLEN-1:0] test2,
  output logic [XLEN-1:0] test3
);
  import register_pkg::*;

  logic [XLEN-1:0] regs_r [NREG];
  logic            wr_en_s;

  // The same qualified enable drives both the store and the bypass, so reset
  // suppresses each of them.
  assign wr_en_s = rst_n && we && (waddr != {AW{1'b0}}) && (int'(waddr) < NREG);

  // Zero or out-of-range addresses read 0. A pending write to the addressed
  // register is returned before the clock edge.
  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = {XLEN{1'b0}};
    if (addr == {AW{1'b0}}) begin
      val = {XLEN{1'b0}};
    end else if (wr_en_s && (addr == waddr)) begin
      val = wdata;
    end else if (int'(addr) < NREG) begin
      val = regs_r[addr];
    end else begin
      val = {XLEN{1'b0}};
    end
    return val;
  endfunction

  // Storage update. The write address is the only index used, so an unknown
  // read address cannot disturb any stored value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read port 1 with bypass.
  always_comb begin
    rs1 = {XLEN{1'b0}};
    rs1 = read_mux(rs1addr);
  end

  // Read port 2 with bypass.
  always_comb begin
    rs2 = {XLEN{1'b0}};
    rs2 = read_mux(rs2addr);
  end

  // The debug taps show stored contents only, with no bypass.
  assign test0 = regs_r[1];
  assign test1 = regs_r[2];
  assign test2 = regs_r[3];
  assign test3 = regs_r[4];

endmodule

// File: tb/tb_register.sv
// Self-checking bench for the register file: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_register;
  import register_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  regaddr_t waddr;
  logic     we;
  word_t    wdata;
  regaddr_t rs1addr;
  word_t    rs1;
  regaddr_t rs2addr;
  word_t    rs2;
  word_t    test0, test1, test2, test3;

  word_t mem [NREG];
  int    compared   = 0;
  int    mismatched = 0;
  int    step       = 0;

  always #5 clk = ~clk;

  register #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .we(we), .wdata(wdata),
    .rs1addr(rs1addr), .rs1(rs1), .rs2addr(rs2addr), .rs2(rs2),
    .test0(test0), .test1(test1), .test2(test2), .test3(test3)
  );

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference read: 0 at address 0, otherwise the pending write if it targets
  // this address and is allowed, else the stored value.
  function automatic word_t exp_rd(input regaddr_t a);
    if (a == 5'd0) return 32'd0;
    if (rst_n === 1'b1 && we === 1'b1 && waddr != 5'd0 && waddr == a) return wdata;
    return mem[a];
  endfunction

  task automatic check_all(input string phase, input bit chk_rs1);
    if (chk_rs1) chk($sformatf("rs1_%s_%0d", phase, step), rs1, exp_rd(rs1addr));
    chk($sformatf("rs2_%s_%0d", phase, step), rs2, exp_rd(rs2addr));
    chk($sformatf("test0_%s_%0d", phase, step), test0, mem[1]);
    chk($sformatf("test1_%s_%0d", phase, step), test1, mem[2]);
    chk($sformatf("test2_%s_%0d", phase, step), test2, mem[3]);
    chk($sformatf("test3_%s_%0d", phase, step), test3, mem[4]);
  endtask

  // One cycle: drive, check combinational view, take the edge, update the model,
  // check again with the same inputs still applied.
  task automatic apply(input logic r, input logic w, input regaddr_t wa, input word_t wd,
                       input regaddr_t a1, input regaddr_t a2, input bit chk_rs1);
    step++;
    rst_n = r; we = w; waddr = wa; wdata = wd; rs1addr = a1; rs2addr = a2;
    #1;
    check_all("pre", chk_rs1);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < NREG; i++) mem[i] = 32'd0;
    end else if (w && wa != 5'd0) begin
      mem[wa] = wd;
    end
    #1;
    check_all("post", chk_rs1);
  endtask

  initial begin
    regaddr_t ra, rb, rw;
    rst_n = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'd0; rs1addr = 5'd0; rs2addr = 5'd0;
    @(posedge clk);
    for (int i = 0; i < NREG; i++) mem[i] = 32'd0;
    #1;
    check_all("reset", 1'b1);

    apply(1'b1, 1'b0, 5'd1, 32'd1, 5'd0, 5'd0, 1'b1);
    apply(1'b1, 1'b1, 5'd1, 32'd1, 5'd1, 5'd0, 1'b1);
    apply(1'b1, 1'b1, 5'd0, 32'd1, 5'd0, 5'd0, 1'b1);
    apply(1'b1, 1'b1, 5'd2, 32'd3, 5'd1, 5'd2, 1'b1);
    apply(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd4, 1'b1);
    apply(1'b1, 1'b1, 5'd4, 32'd5, 5'd3, 5'd4, 1'b1);
    apply(1'b0, 1'b1, 5'd5, 32'd9, 5'd5, 5'd3, 1'b1);
    apply(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd3, 1'b1);
    apply(1'b1, 1'b1, 5'd4, 32'd7, 5'd4, 5'd4, 1'b1);
    apply(1'b1, 1'b1, 5'd2, 32'hA5A5_0F0F, 5'bxxxxx, 5'd2, 1'b0);
    apply(1'b1, 1'b0, 5'd0, 32'd0, 5'bxxxxx, 5'd4, 1'b0);
    apply(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31, 1'b1);

    for (int n = 0; n < 300; n++) begin
      rw = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 7));
      apply(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), rw, word_t'($urandom()),
            ra, rb, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
